// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the single-port RAM access arbiter.
package ram_arb_pkg;

  localparam int unsigned AddrWDefault = 16;
  localparam int unsigned DataWDefault = 32;
  // Wide enough to hold RD_LAT-1 for RD_LAT up to 4.
  localparam int unsigned LatCntW      = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdIssue,
    StRdWait,
    StRdDone
  } arb_state_t;

  typedef enum logic {
    OwnWrite,
    OwnRead
  } arb_owner_t;

endpackage

// File: rtl/ram_arb_lat_counter.sv
// Loadable down-counter that times the read-wait phase; done_o flags a zero count.
module ram_arb_lat_counter
  import ram_arb_pkg::*;
#(
  parameter int unsigned Width = LatCntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ram_access_arbiter.sv
// Serialises a write requester and a read requester onto one synchronous single-port RAM.
// Define ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise writes always win.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic              busy_o
);

  localparam logic [LatCntW-1:0] LatLoad = LatCntW'(RD_LAT - 1);

  arb_state_t        state_q;
  logic              wr_gnt_q, rd_gnt_q, rd_valid_q, ram_wren_q;
  logic [DATA_W-1:0] rd_data_q, ram_data_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              grant_wr, grant_rd;
  logic              lat_done;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_winner_q;

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == StIdle) begin
      if (wr_req_i && rd_req_i) begin
        grant_wr = (last_winner_q == OwnRead);
        grant_rd = (last_winner_q == OwnWrite);
      end else begin
        grant_wr = wr_req_i;
        grant_rd = rd_req_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_winner_q <= OwnRead;
    end else if (grant_wr) begin
      last_winner_q <= OwnWrite;
    end else if (grant_rd) begin
      last_winner_q <= OwnRead;
    end
  end
`else
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == StIdle) begin
      grant_wr = wr_req_i;
      grant_rd = rd_req_i && !wr_req_i;
    end
  end
`endif

  // Counter is loaded while issuing so it holds RD_LAT-1 on the first wait cycle.
  ram_arb_lat_counter #(
    .Width(LatCntW)
  ) u_lat_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (state_q == StRdIssue),
    .load_val_i (LatLoad),
    .en_i       (state_q == StRdWait),
    .done_o     (lat_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      ram_wren_q <= 1'b0;
      rd_data_q  <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      ram_wren_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_wr) begin
            state_q    <= StWrite;
            wr_gnt_q   <= 1'b1;
            ram_wren_q <= 1'b1;
            ram_addr_q <= wr_addr_i;
            ram_data_q <= wr_data_i;
          end else if (grant_rd) begin
            state_q    <= StRdIssue;
            rd_gnt_q   <= 1'b1;
            ram_addr_q <= rd_addr_i;
          end
        end
        StWrite:   state_q <= StIdle;
        StRdIssue: state_q <= StRdWait;
        StRdWait: begin
          if (lat_done) begin
            state_q    <= StRdDone;
            rd_valid_q <= 1'b1;
            rd_data_q  <= ram_q_i;
          end
        end
        StRdDone:  state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign wr_gnt_o   = wr_gnt_q;
  assign rd_gnt_o   = rd_gnt_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign ram_wren_o = ram_wren_q;
  assign busy_o     = (state_q != StIdle);

endmodule
